// File: rtl/test_result_collector_if.sv
// rtl/test_result_collector_if.sv - result/summary handshake bundle for the test result collector
interface test_result_collector_if #(
  parameter int ID_W  = 8,
  parameter int CNT_W = 16
);
  logic             run_start;
  logic             run_end;
  logic             res_valid;
  logic             res_ready;
  logic             res_pass;
  logic [ID_W-1:0]  res_id;
  logic             sum_valid;
  logic             sum_ready;
  logic [CNT_W-1:0] sum_pass_cnt;
  logic [CNT_W-1:0] sum_fail_cnt;
  logic [ID_W-1:0]  sum_first_fail_id;
  logic [1:0]       sum_status;

  modport master (
    output run_start, run_end, res_valid, res_pass, res_id, sum_ready,
    input  res_ready, sum_valid, sum_pass_cnt, sum_fail_cnt, sum_first_fail_id, sum_status
  );

  modport slave (
    input  run_start, run_end, res_valid, res_pass, res_id, sum_ready,
    output res_ready, sum_valid, sum_pass_cnt, sum_fail_cnt, sum_first_fail_id, sum_status
  );
endinterface

// File: rtl/test_result_collector.sv
// rtl/test_result_collector.sv - buffers per-test results and reports a pass/fail summary per run
module test_result_collector #(
  parameter int ID_W       = 8,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  test_result_collector_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [ID_W:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [ID_W-1:0]  first_fail_id;
  logic             fail_seen;
  logic             ready;
  logic             sum_valid;
  logic [1:0]       status;
  logic             push;
  logic             pop;
  logic             clear;
  logic [ID_W:0]    head;

  assign head  = fifo_mem[rd_ptr];
  assign push  = ready & bus.res_valid;
  assign pop   = ((state_q == RUN) || (state_q == DRAIN)) && (fifo_cnt != '0);
  assign clear = (state_q == IDLE) && bus.run_start;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ready depends only on the registered count, so a pop never frees a slot in the same cycle
  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    sum_valid = 1'b0;
    status    = 2'b00;
    case (state_q)
      IDLE:   if (bus.run_start) state_d = RUN;
      RUN: begin
        ready = (fifo_cnt != DEPTH_CNT);
        if (bus.run_end) state_d = DRAIN;
      end
      DRAIN:  if (fifo_cnt == '0) state_d = REPORT;
      REPORT: begin
        sum_valid = 1'b1;
        if (fail_cnt != '0)      status = 2'b10;
        else if (pass_cnt != '0) status = 2'b01;
        if (bus.sum_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.res_pass, bus.res_id};
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // counters saturate at all-ones; the first popped failure owns sum_first_fail_id
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pass_cnt      <= '0;
      fail_cnt      <= '0;
      first_fail_id <= '0;
      fail_seen     <= 1'b0;
    end else if (pop) begin
      if (head[ID_W]) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        if (!fail_seen) begin
          first_fail_id <= head[ID_W-1:0];
          fail_seen     <= 1'b1;
        end
      end
    end
  end

  assign bus.res_ready         = ready;
  assign bus.sum_valid         = sum_valid;
  assign bus.sum_pass_cnt      = pass_cnt;
  assign bus.sum_fail_cnt      = fail_cnt;
  assign bus.sum_first_fail_id = first_fail_id;
  assign bus.sum_status        = status;
endmodule

// File: doc/test_result_collector.md
TEST_RESULT_COLLECTOR -- requirements
Module: test_result_collector

Interface
REQ-001 Parameter ID_W, default 8, width of the test identifier.
REQ-002 Parameter CNT_W, default 16, width of the pass/fail counters.
REQ-003 Parameter FIFO_DEPTH, default 4, result buffer entries (power of two, >=2).
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 run_start  input  1  pulse that opens a run.
REQ-007 run_end  input  1  pulse that closes a run.
REQ-008 res_valid  input  1  upstream testcase result is offered.
REQ-009 res_ready  output  1  collector accepts a result this cycle.
REQ-010 res_pass  input  1  1 = test passed, 0 = failed.
REQ-011 res_id  input  ID_W  identifier of the reporting test.
REQ-012 sum_valid  output  1  run summary is presented.
REQ-013 sum_ready  input  1  downstream consumes the summary.
REQ-014 sum_pass_cnt  output  CNT_W  passing results in the run.
REQ-015 sum_fail_cnt  output  CNT_W  failing results in the run.
REQ-016 sum_first_fail_id  output  ID_W  res_id of the first failing result, 0 if none.
REQ-017 sum_status  output  2  00 NONE (no results), 01 PASS, 10 FAIL; 11 never driven.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN and REPORT.
REQ-019 IDLE: res_ready=0, sum_valid=0; run_start=1 -> clear counters, fail_seen and first_fail_id; go to RUN.
REQ-020 RUN: res_ready = FIFO not full; a handshake (res_valid & res_ready) writes {res_pass,res_id} into the FIFO.
REQ-021 RUN: run_end=1 -> DRAIN next cycle; a handshake in the same cycle as run_end is still accepted and counted.
REQ-022 run_start outside IDLE, and run_end outside RUN, SHALL be ignored.
REQ-023 In RUN and DRAIN, one FIFO entry SHALL be popped per cycle while the FIFO is non-empty; an entry written at edge t is poppable at edge t+1 at the earliest.
REQ-024 A pop SHALL increment sum_pass_cnt or sum_fail_cnt at the same edge; with an empty FIFO, a result handshaken in cycle t is visible on the counter in cycle t+2.
REQ-025 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 The first failing entry popped in a run SHALL latch its id into sum_first_fail_id; later failures leave it unchanged.
REQ-027 Simultaneous write and pop SHALL be allowed when the FIFO is full only for the pop; res_ready is computed from the registered FIFO count, with no combinational path from pop.
REQ-028 DRAIN: res_ready=0; when the FIFO is empty and no pop is pending -> REPORT.
REQ-029 REPORT: sum_valid=1, sum_status = FAIL if fail count >0, else PASS if pass count >0, else NONE.
REQ-030 All sum_* outputs SHALL hold stable while sum_valid=1 and sum_ready=0.
REQ-031 sum_valid & sum_ready -> IDLE next cycle; counters keep their values until the next run_start.

Reset
REQ-032 rst=1 SHALL force IDLE, FIFO empty, res_ready=0, sum_valid=0, both counters 0, sum_first_fail_id=0 and sum_status=00 at the next edge.
REQ-033 Reset asserted mid-RUN, DRAIN or REPORT SHALL discard buffered results and any pending summary, with no summary emitted.

Verification
REQ-034 run_start, then 3 passes (ids 1,2,3) back-to-back, then run_end, with sum_ready=1 -> single sum_valid pulse: pass=3, fail=0, status=01, first_fail_id=0.
REQ-035 Results pass id5, fail id9, fail id12 -> pass=1, fail=2, first_fail_id=9, status=10.
REQ-036 run_start then run_end with no results -> counts 0, status=00; sum_ready held 0 for 5 cycles -> outputs stable, then consumed, then IDLE.
REQ-037 res_valid held 1 with FIFO_DEPTH=4 and pops stalled by a reduced-depth model -> res_ready falls at full and no result is lost; run_end coincident with the last handshake -> that result is counted.
REQ-038 CNT_W=2 with 5 passes -> sum_pass_cnt=3 (saturated).
REQ-039 rst pulsed in DRAIN with 2 entries buffered -> next cycle IDLE, counters 0, no sum_valid.
